// File: rtl/keypad_pkg.sv
// Shared key codes, scan frame length and the per-frame accumulator used by the keypad path.
package keypad_pkg;

   localparam logic [3:0] KEY_NONE  = 4'hf;
   localparam logic [3:0] KEY_CLR   = 4'hc;
   localparam logic [3:0] KEY_ENT   = 4'hd;
   localparam int         SCAN_ROWS = 4;

   typedef struct packed {
      logic       multi;
      logic [3:0] code;
   } frame_acc_t;

   // Keep the first key seen in a frame; a second, different key poisons the frame.
   function automatic frame_acc_t frame_merge(input frame_acc_t acc, input logic [3:0] kv);
      frame_acc_t r;
      r = acc;
      if (kv != KEY_NONE) begin
         if (acc.code == KEY_NONE) begin
            r.code = kv;
         end else if (acc.code != kv) begin
            r.multi = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] frame_code(input frame_acc_t acc);
      return acc.multi ? KEY_NONE : acc.code;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Folds 4-cycle scan frames into frame codes, debounces across frames, strobes on each new press.
// Pulse lands 1 cycle after the commit of the STABLE_FRAMES-th identical frame; no backpressure.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int STABLE_FRAMES = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] key_value_i,
   output logic       key_pulse_o,
   output logic [3:0] key_code_o
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_FRAMES);
   localparam logic [1:0] LAST_ROW   = 2'(SCAN_ROWS - 1);

   logic [1:0] frame_cnt_q;
   frame_acc_t acc_q, acc_d, acc_merged;
   logic [3:0] cand_q, cand_d;
   logic [7:0] stable_q, stable_d;
   logic [3:0] deb_q, deb_d;
   logic       pulse_q, pulse_d;
   logic [3:0] code_q, code_d;
   logic [3:0] commit_code;
   logic       frame_last;

   always_comb begin
      acc_merged  = frame_merge(acc_q, key_value_i);
      commit_code = frame_code(acc_merged);
      frame_last  = (frame_cnt_q == LAST_ROW);
      acc_d       = acc_merged;
      cand_d      = cand_q;
      stable_d    = stable_q;
      if (frame_last) begin
         acc_d = '{multi: 1'b0, code: KEY_NONE};
         if (commit_code == cand_q) begin
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 8'd1;
         end else begin
            cand_d   = commit_code;
            stable_d = 8'd1;
         end
      end
      deb_d   = (stable_d == STABLE_MAX) ? cand_d : deb_q;
      // Only a transition out of "no key" counts; key-to-key changes need a release first.
      pulse_d = (deb_q == KEY_NONE) && (deb_d != KEY_NONE);
      code_d  = pulse_d ? deb_d : code_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_cnt_q <= 2'd0;
         acc_q       <= '{multi: 1'b0, code: KEY_NONE};
         cand_q      <= KEY_NONE;
         stable_q    <= 8'd0;
         deb_q       <= KEY_NONE;
         pulse_q     <= 1'b0;
         code_q      <= KEY_NONE;
      end else begin
         frame_cnt_q <= frame_cnt_q + 2'd1;
         acc_q       <= acc_d;
         cand_q      <= cand_d;
         stable_q    <= stable_d;
         deb_q       <= deb_d;
         pulse_q     <= pulse_d;
         code_q      <= code_d;
      end
   end

   assign key_pulse_o = pulse_q;
   assign key_code_o  = code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced press events build a BCD entry submitted over valid/ready.
// Buffer updates 1 cycle after key_pulse; entry_value holds until entry_ready, new submits wait.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int DIGITS        = 3,
   parameter int STABLE_FRAMES = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [3:0]            key_value_i,
   output logic                  key_pulse_o,
   output logic [3:0]            key_code_o,
   output logic [4*DIGITS-1:0]   entry_digits_o,
   output logic [3:0]            entry_count_o,
   output logic                  entry_valid_o,
   output logic [4*DIGITS-1:0]   entry_value_o,
   input  logic                  entry_ready_i
);

   localparam int         ENTRY_W  = 4 * DIGITS;
   localparam logic [3:0] DIGITS_C = 4'(DIGITS);

   logic               pulse;
   logic [3:0]         code;
   logic [ENTRY_W-1:0] digits_q, digits_d;
   logic [3:0]         count_q, count_d;
   logic               valid_q, valid_d;
   logic [ENTRY_W-1:0] value_q, value_d;

   keypad_debounce #(
      .STABLE_FRAMES (STABLE_FRAMES)
   ) u_debounce (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .key_value_i (key_value_i),
      .key_pulse_o (pulse),
      .key_code_o  (code)
   );

   always_comb begin
      digits_d = digits_q;
      count_d  = count_q;
      valid_d  = valid_q;
      value_d  = value_q;
      if (valid_q && entry_ready_i) begin
         valid_d = 1'b0;
      end
      if (pulse) begin
         if (code <= 4'h9) begin
            if (count_q < DIGITS_C) begin
               digits_d = (digits_q << 4) | ENTRY_W'(code);
               count_d  = count_q + 4'd1;
            end
         end else if (code == KEY_CLR) begin
            digits_d = '0;
            count_d  = 4'd0;
         end else if (code == KEY_ENT) begin
            // Enter never overwrites a pending entry, so submit and consume cannot collide.
            if ((count_q != 4'd0) && !valid_q) begin
               value_d  = digits_q;
               valid_d  = 1'b1;
               digits_d = '0;
               count_d  = 4'd0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         digits_q <= '0;
         count_q  <= 4'd0;
         valid_q  <= 1'b0;
         value_q  <= '0;
      end else begin
         digits_q <= digits_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         value_q  <= value_d;
      end
   end

   assign key_pulse_o    = pulse;
   assign key_code_o     = code;
   assign entry_digits_o = digits_q;
   assign entry_count_o  = count_q;
   assign entry_valid_o  = valid_q;
   assign entry_value_o  = value_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: scan frames are driven row by row, results checked against hand values.
module tb_keypad_entry;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key_value;
   logic        key_pulse;
   logic [3:0]  key_code;
   logic [11:0] entry_digits;
   logic [3:0]  entry_count;
   logic        entry_valid;
   logic [11:0] entry_value;
   logic        entry_ready;

   int n_tests  = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;
   int long_pulse = 0;
   logic prev_pulse = 1'b0;
   int p_before;

   always #5 clk = ~clk;

   keypad_entry #(
      .DIGITS        (3),
      .STABLE_FRAMES (4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .key_value_i    (key_value),
      .key_pulse_o    (key_pulse),
      .key_code_o     (key_code),
      .entry_digits_o (entry_digits),
      .entry_count_o  (entry_count),
      .entry_valid_o  (entry_valid),
      .entry_value_o  (entry_value),
      .entry_ready_i  (entry_ready)
   );

   always @(negedge clk) begin
      if (!rst && key_pulse) begin
         pulse_cnt = pulse_cnt + 1;
         if (prev_pulse) long_pulse = long_pulse + 1;
      end
      prev_pulse = key_pulse && !rst;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One scan frame: a on row 1, b on row 2, no key on the other rows.
   task automatic frame(input logic [3:0] a, input logic [3:0] b);
      for (int i = 0; i < 4; i++) begin
         key_value = (i == 1) ? a : ((i == 2) ? b : 4'hf);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold(input logic [3:0] k, input int n);
      repeat (n) frame(k, 4'hf);
   endtask

   task automatic tap(input logic [3:0] k);
      hold(k, 6);
      hold(4'hf, 5);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      key_value   = 4'hf;
      entry_ready = 1'b0;
      do_reset(3);

      check("rst_pulse", 32'(key_pulse), 32'd0);
      check("rst_code", 32'(key_code), 32'hf);
      check("rst_digits", 32'(entry_digits), 32'h0);
      check("rst_count", 32'(entry_count), 32'd0);
      check("rst_valid", 32'(entry_valid), 32'd0);
      check("rst_value", 32'(entry_value), 32'h0);

      repeat (25) frame(4'hf, 4'hf);
      check("idle_pulses", 32'(pulse_cnt), 32'd0);
      check("idle_code", 32'(key_code), 32'hf);
      check("idle_count", 32'(entry_count), 32'd0);

      // Clean '5': pulse exactly one cycle after the 4th frame commits
      hold(4'h5, 3);
      check("p5_early", 32'(pulse_cnt), 32'd0);
      hold(4'h5, 1);
      check("p5_lat_pulse", 32'(key_pulse), 32'd1);
      check("p5_lat_code", 32'(key_code), 32'h5);
      hold(4'h5, 2);
      hold(4'hf, 5);
      check("p5_pulses", 32'(pulse_cnt), 32'd1);
      check("p5_code", 32'(key_code), 32'h5);
      check("p5_count", 32'(entry_count), 32'd1);
      check("p5_digits", 32'(entry_digits), 32'h005);

      // Bounce on '7' then stable
      repeat (3) begin
         hold(4'h7, 1);
         hold(4'hf, 1);
      end
      check("bounce_none", 32'(pulse_cnt), 32'd1);
      hold(4'h7, 3);
      check("bounce_early", 32'(pulse_cnt), 32'd1);
      hold(4'h7, 1);
      check("bounce_pulse", 32'(key_pulse), 32'd1);
      check("bounce_code", 32'(key_code), 32'h7);
      hold(4'h7, 1);
      hold(4'hf, 5);
      check("bounce_pulses", 32'(pulse_cnt), 32'd2);
      check("bounce_digits", 32'(entry_digits), 32'h057);
      check("bounce_count", 32'(entry_count), 32'd2);

      tap(4'hc);
      check("clr_digits", 32'(entry_digits), 32'h0);
      check("clr_count", 32'(entry_count), 32'd0);

      // Entry 1,2,3,4 with DIGITS=3, then enter
      tap(4'h1);
      tap(4'h2);
      tap(4'h3);
      check("ent_digits3", 32'(entry_digits), 32'h123);
      tap(4'h4);
      check("ent_full_digits", 32'(entry_digits), 32'h123);
      check("ent_full_count", 32'(entry_count), 32'd3);
      tap(4'hd);
      check("sub_valid", 32'(entry_valid), 32'd1);
      check("sub_value", 32'(entry_value), 32'h123);
      check("sub_count", 32'(entry_count), 32'd0);
      check("sub_digits", 32'(entry_digits), 32'h0);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check("hold_valid", 32'(entry_valid), 32'd1);
      check("hold_value", 32'(entry_value), 32'h123);

      // Typing while pending is allowed; enter while pending is ignored
      tap(4'h8);
      check("pend_digits", 32'(entry_digits), 32'h008);
      tap(4'hd);
      check("pend_ent_valid", 32'(entry_valid), 32'd1);
      check("pend_ent_value", 32'(entry_value), 32'h123);
      check("pend_ent_count", 32'(entry_count), 32'd1);
      check("pend_ent_digits", 32'(entry_digits), 32'h008);

      entry_ready = 1'b1;
      check("rdy_same_cycle", 32'(entry_valid), 32'd1);
      @(posedge clk);
      #1;
      entry_ready = 1'b0;
      check("rdy_drop", 32'(entry_valid), 32'd0);
      @(posedge clk);
      #1;
      check("rdy_stays_low", 32'(entry_valid), 32'd0);

      // Clear then empty enter
      tap(4'h9);
      check("c9_digits", 32'(entry_digits), 32'h089);
      tap(4'hc);
      check("c9_clr_digits", 32'(entry_digits), 32'h0);
      check("c9_clr_count", 32'(entry_count), 32'd0);
      tap(4'hd);
      check("empty_ent_valid", 32'(entry_valid), 32'd0);
      check("empty_ent_count", 32'(entry_count), 32'd0);

      // Two keys in the same frames
      p_before = pulse_cnt;
      repeat (6) frame(4'h2, 4'h6);
      hold(4'hf, 5);
      check("multi_pulses", 32'(pulse_cnt - p_before), 32'd0);
      check("multi_count", 32'(entry_count), 32'd0);

      // Reset in the middle of a debounce, with stale entry_value present
      p_before = pulse_cnt;
      hold(4'h3, 3);
      do_reset(2);
      check("mrst_code", 32'(key_code), 32'hf);
      check("mrst_value", 32'(entry_value), 32'h0);
      check("mrst_pulse", 32'(key_pulse), 32'd0);
      hold(4'h3, 3);
      check("mrst_early", 32'(pulse_cnt - p_before), 32'd0);
      hold(4'h3, 1);
      check("mrst_pulse_after", 32'(key_pulse), 32'd1);
      check("mrst_code_after", 32'(key_code), 32'h3);
      hold(4'hf, 5);
      check("mrst_pulses", 32'(pulse_cnt - p_before), 32'd1);
      check("mrst_digits", 32'(entry_digits), 32'h003);

      check("pulse_width", 32'(long_pulse), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Sits directly downstream of the 3x4 keypad row scanner.
- Consumes its raw per-cycle key_value code stream (4'hf = no key in the currently scanned row). Folds every 4-cycle scan frame into one frame code, then debounces across frames.
- Emits one-cycle key press events. Assembles digit presses into a multi-digit BCD entry that is handed to game logic through a valid/ready handshake.
- Key codes: 4'h0-4'h9 digits, 4'hc clear, 4'hd enter, 4'hf none.

Parameters:
- DIGITS, 3, number of BCD digits held in the entry buffer (1..8).
- STABLE_FRAMES, 4, consecutive identical frame codes required to accept a debounced code (2..255).

Ports:
- clk  input  1  system clock, same clock as the keypad scanner.
- rst  input  1  synchronous active-high reset.
- key_value  input  4  raw code from the scanner, one row per cycle.
- key_pulse  output  1  one-cycle strobe on each accepted key press.
- key_code  output  4  code of the last accepted press; valid while key_pulse=1 and held afterwards.
- entry_digits  output  4*DIGITS  live BCD buffer; most recent digit in [3:0].
- entry_count  output  4  number of digits currently in the buffer (0..DIGITS).
- entry_valid  output  1  submitted entry is pending.
- entry_value  output  4*DIGITS  submitted BCD entry; stable while entry_valid=1.
- entry_ready  input  1  consumer accepts the entry on a cycle where entry_valid & entry_ready.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - key_pulse=0, key_code=4'hf
  - entry_digits=0, entry_count=0
  - entry_valid=0, entry_value=0
  - frame counter=0, accumulator=4'hf
  - debounced code=4'hf, stable counter=0
- Reset mid-frame or mid-handshake discards everything; no pulse is issued on the cycle reset is released.
- Frame aggregation:
  - A 2-bit frame counter increments every cycle and wraps 3->0.
  - Within a frame, the accumulator takes the first non-f key_value seen.
  - If a second, different non-f value is seen in the same frame (multi-key), the frame is marked invalid and its frame code is 4'hf.
  - On the cycle the counter=3, the frame code is (accumulator merged with that cycle's key_value) and is committed. The accumulator then returns to 4'hf.
- Debounce:
  - If the committed frame code equals the candidate code, the stable counter increments, saturating at STABLE_FRAMES.
  - Otherwise the candidate is replaced and the stable counter is set to 1.
  - When the stable counter reaches STABLE_FRAMES, the debounced code is set to the candidate.
- Press event:
  - key_pulse=1 for exactly one cycle, the cycle after the debounced code changes from 4'hf to a non-f code. key_code is loaded in the same cycle.
  - A change from one non-f code directly to another does not pulse; release (debounced 4'hf) is required first.
  - Holding a key generates no repeats.
- Latency: a clean press first appearing in frame k pulses 1 cycle after the commit of frame k+STABLE_FRAMES-1.
- Entry buffer, acted on only in key_pulse cycles:
  - Digit 0-9, count<DIGITS: entry_digits shifts left by 4, the digit enters [3:0], count+1.
  - Digit 0-9, count==DIGITS: ignored (full).
  - 4'hc: entry_digits=0, count=0.
  - 4'hd with count>0 and entry_valid=0: entry_value <= entry_digits, entry_valid=1, buffer cleared, count=0.
  - 4'hd with count==0, or while entry_valid=1: ignored; the buffer is kept.
- Handshake:
  - entry_valid stays high with entry_value stable until a cycle with entry_ready=1. It falls on the following edge.
  - entry_ready with entry_valid=0 has no effect.
  - A submit and a consume in the same cycle cannot occur: submit requires entry_valid=0.
  - Digits may be typed into the buffer while an entry is pending.

Decomposition:
- Shared package (keypad_pkg):
  - key code constants KEY_NONE=4'hf, KEY_CLR=4'hc, KEY_ENT=4'hd
  - frame length constant SCAN_ROWS=4
- One sub-module is natural: keypad_debounce (frame aggregation + debounce + press-edge detect; outputs key_pulse/key_code).
- The entry buffer and handshake stay in the top module.

Test Plan:
- Idle: key_value=4'hf for 100 cycles -> key_pulse never asserts; all outputs remain at reset values.
- Clean press of '5':
  - Stimulus: key_value=4'h5 on one cycle per frame for 6 frames, STABLE_FRAMES=4.
  - Required: exactly one key_pulse with key_code=4'h5; entry_count=1; entry_digits[3:0]=4'h5.
- Bounce:
  - Stimulus: '7' alternating with 4'hf frame by frame for 6 frames, then stable '7'.
  - Required: a single pulse only after 4 stable frames; no pulse during the bounce.
- Entry and submit:
  - Stimulus: presses 1,2,3,4 (DIGITS=3), then 'd', with entry_ready=0 for 10 cycles, then 1.
  - Required: '4' is ignored; entry_value=12'h123 with entry_valid held; entry_valid drops one cycle after ready; count=0.
- Clear and empty enter:
  - Stimulus: presses 9,'c','d'.
  - Required: buffer is 0 after 'c'; 'd' produces no entry_valid.
- Multi-key and reset:
  - Stimulus: '2' and '6' both appear in the same frames -> no pulse.
  - Stimulus: rst asserted in the middle of a press debounce -> no pulse after release of reset until a fresh press is fully debounced.
